fetch_unit: RTL and testbench

//   Instruction fetch stage: owns the PC, issues in-order word requests to instruction memory,

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_queue.sv | 44 ++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: packet carried to decode, FSM states, reset vector.
// Pure declarations; no timing or flow control lives here.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR        = 32'h0000_0000;
    localparam int unsigned DEFAULT_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] InstructionWord;
        logic [31:0] PC;
    } FetchPacket_t;

    typedef enum logic [0:0] {
        FETCH_STATE_FETCH  = 1'b0,
        FETCH_STATE_HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-request and decode-side signals of the fetch stage; master = fetch unit.
// Request is valid/ready; decode side pops with o_Valid & !i_Stall; responses arrive in order.
interface fetch_unit_if;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemReady;
    logic        i_IMemRespValid;
    logic [31:0] i_IMemRespData;
    logic        o_Valid;
    logic [31:0] o_InstructionWord;
    logic [31:0] o_PC;
    logic        i_Stall;
    logic        i_Redirect;
    logic [31:0] i_RedirectTarget;
    logic        o_FetchMisaligned;

    modport master (
        output o_IMemReq, o_IMemAddr,
        input  i_IMemReady, i_IMemRespValid, i_IMemRespData,
        output o_Valid, o_InstructionWord, o_PC,
        input  i_Stall, i_Redirect, i_RedirectTarget,
        output o_FetchMisaligned
    );

    modport slave (
        input  o_IMemReq, o_IMemAddr,
        output i_IMemReady, i_IMemRespValid, i_IMemRespData,
        input  o_Valid, o_InstructionWord, o_PC,
        output i_Stall, i_Redirect, i_RedirectTarget,
        input  o_FetchMisaligned
    );
endinterface

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush; head is read straight from registered storage (push -> head next cycle).
// No internal backpressure: caller must not push when full unless popping in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_PushData,
    input  logic                     i_Pop,
    input  logic                     i_Flush,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic [WIDTH-1:0]         o_Head
);
    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_Count   = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = i_Pop && (o_Count != '0);
    assign w_do_push = i_Push && ((o_Count != FULL_COUNT) || w_do_pop);
    assign o_Head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_do_push && !i_Flush && !i_Reset) r_mem[r_wr_ptr[AW-1:0]] <= i_PushData;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word requests, queues returned words; response -> o_Valid next cycle.
// Issue is throttled so queued + outstanding never exceeds QUEUE_DEPTH; i_Stall holds the queue head.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_VECTOR,
    parameter int unsigned QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    fetch_unit_if.master  bus
);
    localparam int unsigned   CW        = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(QUEUE_DEPTH);

    fetch_state_t   r_state;
    fetch_state_t   w_state_next;
    logic           w_halted;
    logic [31:0]    r_fetch_pc;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  w_outstanding_next;
    logic [CW-1:0]  r_drop_count;
    logic [CW-1:0]  w_q_count;
    logic [CW-1:0]  w_pc_count;
    FetchPacket_t   w_q_head;
    FetchPacket_t   w_q_push_dat;
    logic [31:0]    w_pc_head;
    logic           w_issue_ok;
    logic           w_accept;
    logic           w_resp;
    logic           w_drop;
    logic           w_push;
    logic           w_pop;
    logic           w_misaligned;

    // Each outstanding request owns a future queue slot, so the queue can never overflow.
    assign w_issue_ok   = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < DEPTH_EXT;
    assign bus.o_IMemReq  = !i_Reset && !w_halted && w_issue_ok;
    assign bus.o_IMemAddr = r_fetch_pc;

    assign w_accept     = bus.o_IMemReq && bus.i_IMemReady;
    assign w_resp       = bus.i_IMemRespValid;
    assign w_misaligned = is_misaligned(bus.i_RedirectTarget);
    assign w_drop       = bus.i_Redirect || (r_drop_count != '0);
    // A response with no live PC recorded is never queued.
    assign w_push       = w_resp && !w_drop && (w_pc_count != '0);
    assign w_pop        = bus.o_Valid && !bus.i_Stall && !bus.i_Redirect;

    assign w_q_push_dat.InstructionWord = bus.i_IMemRespData;
    assign w_q_push_dat.PC              = w_pc_head;

    assign bus.o_Valid           = (w_q_count != '0);
    assign bus.o_InstructionWord = bus.o_Valid ? w_q_head.InstructionWord : 32'h0;
    assign bus.o_PC              = bus.o_Valid ? w_q_head.PC : 32'h0;
    assign bus.o_FetchMisaligned = w_halted;

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_accept && !w_resp)      w_outstanding_next = r_outstanding + CW'(1);
        else if (!w_accept && w_resp) w_outstanding_next = r_outstanding - CW'(1);
    end

    // On redirect every request still in flight, including one accepted now, returns a stale word.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (bus.i_Redirect) begin
                r_drop_count <= w_outstanding_next;
                r_fetch_pc   <= bus.i_RedirectTarget;
            end else begin
                if (w_resp && (r_drop_count != '0)) r_drop_count <= r_drop_count - CW'(1);
                if (w_accept)                       r_fetch_pc   <= r_fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_state <= FETCH_STATE_FETCH;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_halted     = 1'b0;
        unique case (r_state)
            FETCH_STATE_FETCH: begin
                if (bus.i_Redirect && w_misaligned) w_state_next = FETCH_STATE_HALTED;
            end
            FETCH_STATE_HALTED: begin
                w_halted = 1'b1;
                if (bus.i_Redirect && !w_misaligned) w_state_next = FETCH_STATE_FETCH;
            end
            default: w_state_next = FETCH_STATE_FETCH;
        endcase
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(FetchPacket_t))
    ) u_inst_queue (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Push     (w_push),
        .i_PushData (w_q_push_dat),
        .i_Pop      (w_pop),
        .i_Flush    (bus.i_Redirect),
        .o_Count    (w_q_count),
        .o_Head     (w_q_head)
    );

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (32)
    ) u_pc_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Push     (w_accept),
        .i_PushData (r_fetch_pc),
        .i_Pop      (w_push),
        .i_Flush    (bus.i_Redirect),
        .o_Count    (w_pc_count),
        .o_Head     (w_pc_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a request-tagging reference model,
// directed scenarios followed by randomized traffic.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    req_t        outq[$];
    ent_t        fq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          in_reset;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit er;
        er = !in_reset && !m_halt && (fq.size() + outq.size() < DEPTH);
        chk("req",        bus.o_IMemReq, er);
        chk("addr",       bus.o_IMemAddr, m_pc);
        chk("valid",      bus.o_Valid, fq.size() != 0);
        chk("pc",         bus.o_PC, fq.size() != 0 ? fq[0].pc : 32'h0);
        chk("word",       bus.o_InstructionWord, fq.size() != 0 ? fq[0].word : 32'h0);
        chk("misaligned", bus.o_FetchMisaligned, m_halt);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit rdy, input bit rsp, input bit stl, input bit rdr, input logic [31:0] tgt);
        bit   acc, got, popd, exp_req;
        req_t r, nr;
        ent_t e;
        exp_req = !m_halt && (fq.size() + outq.size() < DEPTH);
        got     = rsp && (outq.size() > 0);
        bus.i_IMemReady      = rdy;
        bus.i_IMemRespValid  = got;
        bus.i_IMemRespData   = got ? mem_word(outq[0].addr) : $urandom();
        bus.i_Stall          = stl;
        bus.i_Redirect       = rdr;
        bus.i_RedirectTarget = tgt;
        acc  = exp_req && rdy;
        popd = (fq.size() > 0) && !stl && !rdr;
        r.addr = 32'h0; r.stale = 1'b1;
        if (got) r = outq.pop_front();
        if (rdr) begin
            foreach (outq[i]) outq[i].stale = 1'b1;
            fq.delete();
            if (acc) begin nr.addr = m_pc; nr.stale = 1'b1; outq.push_back(nr); end
            m_pc   = tgt;
            m_halt = (tgt[1:0] != 2'b00);
        end else begin
            if (popd) void'(fq.pop_front());
            if (got && !r.stale) begin e.word = mem_word(r.addr); e.pc = r.addr; fq.push_back(e); end
            if (acc) begin nr.addr = m_pc; nr.stale = 1'b0; outq.push_back(nr); m_pc = m_pc + 32'd4; end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_IMemReady = 1'b0; bus.i_IMemRespValid = 1'b0; bus.i_IMemRespData = 32'h0;
        bus.i_Stall = 1'b0; bus.i_Redirect = 1'b0; bus.i_RedirectTarget = 32'h0;
        @(negedge clk);
        in_reset = 1'b1;
        outq.delete(); fq.delete();
        m_pc = RPC; m_halt = 1'b0;
        compare();
        rst = 1'b0;
        in_reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp, tgt;
        int          pr, pa, ps;
        n_checks = 0; n_fail = 0; in_reset = 1'b0;

        // Reset values
        do_reset();
        chk("rst_req", bus.o_IMemReq, 0);
        chk("rst_valid", bus.o_Valid, 0);
        chk("rst_mis", bus.o_FetchMisaligned, 0);
        chk("rst_pc", bus.o_PC, 0);
        chk("rst_word", bus.o_InstructionWord, 0);
        chk("rst_addr", bus.o_IMemAddr, RPC);

        // Always-ready memory with 1-cycle responses: PCs 0,4,8 on consecutive cycles
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, 0, 0);
            if (k >= 2) begin
                chk("seq_valid", bus.o_Valid, 1);
                chk("seq_pc", bus.o_PC, 32'(4 * (k - 2)));
                chk("seq_word", bus.o_InstructionWord, mem_word(32'(4 * (k - 2))));
            end
        end

        // Stall held: in-flight total saturates at DEPTH and issue stops
        repeat (10) step(1, 1, 1, 0, 0);
        chk("stall_req", bus.o_IMemReq, 0);
        chk("stall_valid", bus.o_Valid, 1);
        chk("stall_inflight", fq.size() + outq.size(), DEPTH);
        repeat (12) step(1, 1, 0, 0, 0);

        // Redirect to 0x100 with three requests outstanding
        repeat (8) step(0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("redir_outstanding", outq.size(), 3);
        step(0, 0, 0, 1, 32'h100);
        chk("redir_flush", bus.o_Valid, 0);
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 0, 0);
            if (bus.o_Valid) break;
        end
        chk("redir_seen", bus.o_Valid, 1);
        chk("redir_pc", bus.o_PC, 32'h100);

        // Misaligned redirect halts fetch; aligned redirect resumes
        step(1, 1, 0, 1, 32'h102);
        chk("mis_flag", bus.o_FetchMisaligned, 1);
        chk("mis_req", bus.o_IMemReq, 0);
        repeat (5) step(1, 1, 0, 0, 0);
        chk("mis_hold", bus.o_IMemReq, 0);
        step(0, 1, 0, 1, 32'h200);
        chk("resume_flag", bus.o_FetchMisaligned, 0);
        chk("resume_req", bus.o_IMemReq, 1);
        chk("resume_addr", bus.o_IMemAddr, 32'h200);
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 0, 0);
            if (bus.o_Valid) break;
        end
        chk("resume_pc", bus.o_PC, 32'h200);

        // PC wraps at the top of the address space
        step(0, 1, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_addr0", bus.o_IMemAddr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0);
        chk("wrap_addr1", bus.o_IMemAddr, 32'h0000_0000);

        // Reset with a populated queue and two requests outstanding
        repeat (8) step(0, 1, 0, 0, 0);
        repeat (2) step(1, 0, 1, 0, 0);
        repeat (2) step(1, 1, 1, 0, 0);
        chk("pre_rst_queue", fq.size(), 2);
        chk("pre_rst_out", outq.size(), 2);
        do_reset();
        chk("mid_rst_valid", bus.o_Valid, 0);
        chk("mid_rst_req", bus.o_IMemReq, 0);
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 0, 0);
            if (bus.o_Valid) break;
        end
        chk("post_rst_pc", bus.o_PC, RPC);

        // Randomized traffic with varying pressure, redirects and occasional resets
        for (int i = 0; i < 4000; i++) begin
            pa = 40 + 15 * ((i / 1000) % 4);
            pr = 90 - 15 * ((i / 800) % 4);
            ps = 10 + 20 * ((i / 500) % 3);
            tmp = $urandom();
            tgt = {tmp[31:2], 2'b00};
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 + {tmp[3:2], 2'b00};
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) < ps, $urandom_range(0, 99) < 4, tgt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
